// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 asynchronous serial transmitter.
// Bytes written on i_serial/i_serial_v are queued and shifted out LSB first,
// with back-to-back frames whenever the queue still holds data at stop end.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    i_serial,
    input  logic                          i_serial_v,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    // Transmitter state
    state_e          state_q,   state_d;
    logic            tx_q,      tx_d;
    logic            busy_q,    busy_d;
    logic [7:0]      shift_q,   shift_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [BW-1:0]   baud_q,    baud_d;

    // FIFO bookkeeping
    logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [AW:0]     count_q,   count_d;
    logic            full_q,    full_d;
    logic            empty_q,   empty_d;
    logic            ovf_q,     ovf_d;

    logic [7:0]      mem [FIFO_DEPTH];

    logic            pop;
    logic            wr_accept;
    logic            baud_tick;
    logic [2:0]      bit_next;

    // A write is taken only when the queue was not full before this edge,
    // so a pop on the same edge can never make room for it.
    assign wr_accept = i_serial_v && !full_q;
    assign baud_tick = (baud_q == BAUD_LAST);
    assign bit_next  = bit_idx_q + 3'd1;

    // Transmitter next-state: framing, bit sequencing and FIFO pop requests
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                baud_d    = '0;
                bit_idx_d = '0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                baud_d = baud_tick ? '0 : baud_q + BW'(1);
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end

            DATA: begin
                baud_d = baud_tick ? '0 : baud_q + BW'(1);
                if (baud_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_next;
                        tx_d      = shift_q[bit_next];
                    end
                end
            end

            STOP: begin
                baud_d = baud_tick ? '0 : baud_q + BW'(1);
                if (baud_tick) begin
                    // Chain straight into the next start bit when data waits,
                    // so consecutive frames carry no idle gap.
                    if (!empty_q) begin
                        pop       = 1'b1;
                        shift_d   = mem[rd_ptr_q];
                        state_d   = START;
                        tx_d      = 1'b0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                baud_d  = '0;
            end
        endcase
    end

    // FIFO next-state: pointers, occupancy, flags and sticky overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({wr_accept, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (i_serial_v && full_q) begin
            ovf_d = 1'b1;
        end

        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    // All control state and registered outputs; reset aborts any frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
        end
    end

    // Byte storage; contents need no reset since occupancy governs validity
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= i_serial;
        end
    end

    assign o_tx       = tx_q;
    assign o_busy     = busy_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_serial;
    logic       i_serial_v;
    logic       o_tx;
    logic       o_busy;
    logic       o_full;
    logic       o_empty;
    logic [2:0] o_count;
    logic       o_overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int max_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] five_bytes [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    logic [7:0] three_abort[3] = '{8'hF0, 8'h11, 8'h22};

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_serial  (i_serial),
        .i_serial_v(i_serial_v),
        .o_tx      (o_tx),
        .o_busy    (o_busy),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_count   (o_count),
        .o_overflow(o_overflow)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checks one 40-cycle frame starting at the next falling clock edge.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int bi = 0; bi < 10; bi++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                @(negedge clk);
                check($sformatf("%s_b%0d_tx", tag, bi), 32'(o_tx), 32'(fr[bi]));
                check($sformatf("%s_b%0d_busy", tag, bi), 32'(o_busy), 32'd1);
                if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
            end
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        i_serial_v = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Receiver model: waits for a start bit, samples mid-bit.
    task automatic rx_byte(output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = '0;
        for (int w = 0; w < 3000; w++) begin
            @(negedge clk);
            if (o_tx == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        repeat (2) @(negedge clk);
        check("rx_start_mid", 32'(o_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = o_tx;
        end
        repeat (CPB) @(negedge clk);
        check("rx_stop_mid", 32'(o_tx), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        bit         done;
        bit         seen_low;
        bit         ok;
        logic [7:0] rb;

        // Reset state; writes ignored while in reset
        rst        = 1'b0;
        i_serial   = 8'hA5;
        i_serial_v = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(o_tx), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);

        // First edge after release accepts the write
        rst = 1'b1;
        @(negedge clk);
        i_serial_v = 1'b0;
        check("first_wr_count", 32'(o_count), 32'd1);
        expect_frame(8'hA5, "fa5");
        @(negedge clk);
        check("fa5_end_busy", 32'(o_busy), 32'd0);
        check("fa5_end_empty", 32'(o_empty), 32'd1);

        // Single byte 0x6C: low one edge after write, 40-cycle frame
        repeat (3) @(negedge clk);
        i_serial   = 8'h6C;
        i_serial_v = 1'b1;
        @(negedge clk);
        i_serial_v = 1'b0;
        check("f6c_wr_count", 32'(o_count), 32'd1);
        check("f6c_wr_empty", 32'(o_empty), 32'd0);
        check("f6c_wr_tx", 32'(o_tx), 32'd1);
        expect_frame(8'h6C, "f6c");
        @(negedge clk);
        check("f6c_end_busy", 32'(o_busy), 32'd0);
        check("f6c_end_tx", 32'(o_tx), 32'd1);

        // Three consecutive writes -> back-to-back frames, peak count 2
        repeat (2) @(negedge clk);
        max_cnt = 0;
        fork
            begin
                i_serial   = 8'h1B;
                i_serial_v = 1'b1;
                @(negedge clk);
                i_serial   = 8'h0D;
                @(negedge clk);
                i_serial   = 8'h0A;
                @(negedge clk);
                i_serial_v = 1'b0;
            end
            begin
                @(negedge clk);
                check("b2b_first_count", 32'(o_count), 32'd1);
                expect_frame(8'h1B, "f1b");
                expect_frame(8'h0D, "f0d");
                expect_frame(8'h0A, "f0a");
            end
        join
        check("b2b_peak_count", 32'(max_cnt), 32'd2);
        @(negedge clk);
        check("b2b_end_busy", 32'(o_busy), 32'd0);
        check("b2b_end_count", 32'(o_count), 32'd0);

        // Five writes fill FIFO without overflow; sixth is dropped
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            i_serial   = five_bytes[i];
            i_serial_v = 1'b1;
            @(negedge clk);
        end
        check("fill_full", 32'(o_full), 32'd1);
        check("fill_count", 32'(o_count), 32'd4);
        check("fill_ovf", 32'(o_overflow), 32'd0);
        i_serial = 8'hEE;
        @(negedge clk);
        i_serial_v = 1'b0;
        check("drop_ovf", 32'(o_overflow), 32'd1);
        check("drop_count", 32'(o_count), 32'd4);
        check("drop_full", 32'(o_full), 32'd1);
        done = 1'b0;
        for (int w = 0; w < 400; w++) begin
            @(negedge clk);
            if (o_empty && !o_busy) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(done), 32'd1);
        check("ovf_sticky", 32'(o_overflow), 32'd1);
        do_reset();
        @(negedge clk);
        check("ovf_cleared", 32'(o_overflow), 32'd0);

        // Full write on the same edge as the stop-end pop is still dropped
        for (int i = 0; i < 5; i++) begin
            i_serial   = five_bytes[i];
            i_serial_v = 1'b1;
            @(negedge clk);
        end
        i_serial_v = 1'b0;
        check("pre_pop_count", 32'(o_count), 32'd4);
        repeat (36) @(negedge clk);
        check("pre_pop_count2", 32'(o_count), 32'd4);
        check("pre_pop_tx", 32'(o_tx), 32'd1);
        check("pre_pop_ovf", 32'(o_overflow), 32'd0);
        i_serial   = 8'h77;
        i_serial_v = 1'b1;
        @(negedge clk);
        i_serial_v = 1'b0;
        check("pop_drop_ovf", 32'(o_overflow), 32'd1);
        check("pop_drop_count", 32'(o_count), 32'd3);
        check("pop_drop_full", 32'(o_full), 32'd0);
        check("pop_drop_tx", 32'(o_tx), 32'd0);
        check("pop_drop_busy", 32'(o_busy), 32'd1);
        do_reset();
        @(negedge clk);

        // Reset during DATA bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) begin
            i_serial   = three_abort[i];
            i_serial_v = 1'b1;
            @(negedge clk);
        end
        i_serial_v = 1'b0;
        check("abort_count", 32'(o_count), 32'd2);
        repeat (16) @(negedge clk);
        check("abort_bit3_tx", 32'(o_tx), 32'd0);
        check("abort_bit3_busy", 32'(o_busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_tx", 32'(o_tx), 32'd1);
        check("abort_cnt", 32'(o_count), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_empty", 32'(o_empty), 32'd1);
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        seen_low = 1'b0;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_busy !== 1'b0) seen_low = 1'b1;
        end
        check("abort_idle_line", 32'(seen_low), 32'd0);
        check("abort_idle_count", 32'(o_count), 32'd0);

        // Random stream of 256 bytes decoded by the receiver model
        fork
            begin
                logic [7:0] wb;
                for (int i = 0; i < 256; i++) begin
                    repeat ($urandom_range(0, 50)) @(negedge clk);
                    for (int w = 0; w < 5000 && o_count == 3'(DEPTH); w++) @(negedge clk);
                    wb         = 8'($urandom);
                    i_serial   = wb;
                    i_serial_v = 1'b1;
                    exp_q.push_back(wb);
                    @(negedge clk);
                    i_serial_v = 1'b0;
                end
            end
            begin
                for (int i = 0; i < 256; i++) begin
                    rx_byte(rb, ok);
                    if (!ok) begin
                        check("rx_timeout", 32'd0, 32'd1);
                        break;
                    end
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected", 32'(rb), 32'hFFFF_FFFF);
                    end else begin
                        check($sformatf("rx_byte%0d", i), 32'(rb), 32'(exp_q.pop_front()));
                    end
                end
            end
        join
        check("rand_no_ovf", 32'(o_overflow), 32'd0);
        check("rand_all_rx", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Downstream serializer for the terminal buffer. It accepts the terminal buffer's byte/valid stream, queues it, and shifts it out as 8N1 asynchronous serial.

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, clk cycles per serial bit (25 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, byte entries; power of two, 2..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_serial  input  8  byte to transmit.
REQ-006 i_serial_v  input  1  write strobe; one byte per high clk cycle.
REQ-007 o_tx  output  1  serial line, idle high.
REQ-008 o_busy  output  1  high while a frame is on the line (START..STOP).
REQ-009 o_full  output  1  high when FIFO holds FIFO_DEPTH bytes.
REQ-010 o_empty  output  1  high when FIFO holds 0 bytes.
REQ-011 o_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 o_overflow  output  1  sticky, set when a write is dropped.

Function
REQ-013 Write: on a rising edge with i_serial_v=1 and o_full=0, i_serial is stored at the write pointer, and the pointer and count increment.
REQ-014 Write when o_full=1 shall drop the byte and set o_overflow; this applies even if a pop occurs the same edge.
REQ-015 Simultaneous accepted write and pop shall leave o_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-016 FSM states IDLE, START, DATA, STOP; all outputs registered.
REQ-017 IDLE: o_tx=1, o_busy=0; if FIFO non-empty: pop head into shift register, go START.
REQ-018 START: o_tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index; after bit 7 go STOP.
REQ-020 STOP: o_tx=1 for CLKS_PER_BIT cycles; at end, if FIFO non-empty pop and go START directly (no idle gap), else go IDLE.
REQ-021 Frame length exactly 10*CLKS_PER_BIT cycles; back-to-back frames have no extra cycles between stop and next start.
REQ-022 Latency: byte written at edge k into empty FIFO with FSM in IDLE shall drive o_tx low after edge k+1.
REQ-023 o_busy=1 from the edge entering START through the last STOP cycle.
REQ-024 Baud counter width clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
REQ-025 Writes during transmission shall not disturb the frame in progress; the shift register is independent of FIFO storage.
REQ-026 o_empty/o_full/o_count shall reflect state after the current edge; no combinational path from i_serial_v to any output.

Reset
REQ-027 rst=0 asynchronously forces: IDLE, o_tx=1, o_busy=0, o_empty=1, o_full=0, o_count=0, o_overflow=0, pointers 0, baud counter 0.
REQ-028 Reset mid-frame shall abort the frame immediately (o_tx=1) and discard all FIFO contents; no partial byte resumes after release.
REQ-029 Writes are ignored while rst=0; the first write is accepted on the first rising edge with rst=1.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4, 20-unit clk)
REQ-030 Single byte 0x6C into idle block -> o_tx low one edge after write, then bits 0,0,1,1,0,1,1,0, stop=1, each 4 cycles; 40 cycles total; o_busy falls after stop.
REQ-031 Three writes 0x1B,0x0D,0x0A on consecutive cycles -> three frames back-to-back, 120 cycles, no idle cycle between frames; o_count peaks at 2.
REQ-032 Five writes on consecutive cycles with FSM idle -> first pops, next four fill FIFO, o_full=1, no overflow; a sixth write while full -> dropped, o_overflow=1 held until reset.
REQ-033 Write with o_full=1 on the same edge as a STOP-end pop -> byte dropped, o_overflow=1, o_count=3 after edge.
REQ-034 rst=0 during DATA bit 3 with 2 bytes queued -> o_tx=1, o_count=0, o_busy=0 immediately; after release, line stays idle until a new write.
REQ-035 Self-check: bench UART receiver model decodes o_tx for 256 random bytes written at random intervals (no overflow) -> received sequence equals written sequence.
